mem_access_ctrl: RTL and testbench

Single-clock initiator that drives the request side of the memory manager's port (`req`, `read_write`, `addr_in_block`, `data_in`, `data_out`) on behalf of one CPU load/store port. It latches one CPU access and holds the memory-port signals stable for a fixed wait window. The window is short for block-RAM addresses and long for cellular-RAM addresses. On the final wait edge it captures read data and pulses a one-cycle completion strobe back to the CPU.

---
 rtl/mem_access_ctrl.sv | 122 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Single-port memory access initiator: latches one CPU load/store and holds the
// memory-port request for a fixed, address-dependent wait window, then reports completion.
module mem_access_ctrl #(
  parameter int BLOCK_WAIT = 2,
  parameter int CELL_WAIT  = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [23:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic [15:0] cpu_rdata,
  output logic        mem_req,
  output logic        mem_read_write,
  output logic [23:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [3:0] BLOCK_LOAD = 4'(BLOCK_WAIT - 1);
  localparam logic [3:0] CELL_LOAD  = 4'(CELL_WAIT - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [23:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        mem_req_q;
  logic        mem_rw_q;
  logic        done_q;

  // Anything outside the low 64 KiB lives in the slower cellular RAM.
  function automatic logic [3:0] wait_load(input logic [23:0] addr);
    if (addr[23:16] != 8'd0) begin
      return CELL_LOAD;
    end else begin
      return BLOCK_LOAD;
    end
  endfunction

  // Next-state, counter and datapath selection
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          if (!we_q) begin
            rdata_d = mem_rdata;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_IDLE, ST_DONE: begin
        if (cpu_req) begin
          state_d = ST_ACCESS;
          cnt_d   = wait_load(cpu_addr);
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with outputs registered from the next state, so they track the state exactly
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      addr_q    <= 24'd0;
      wdata_q   <= 16'd0;
      rdata_q   <= 16'd0;
      mem_req_q <= 1'b0;
      mem_rw_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      mem_req_q <= (state_d == ST_ACCESS);
      mem_rw_q  <= (state_d == ST_ACCESS) && we_d;
      done_q    <= (state_d == ST_DONE);
    end
  end

  assign cpu_busy       = (state_q == ST_ACCESS);
  assign cpu_done       = done_q;
  assign cpu_rdata      = rdata_q;
  assign mem_req        = mem_req_q;
  assign mem_read_write = mem_rw_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a default instance and a BLOCK_WAIT=1/CELL_WAIT=15 instance.
module tb_mem_access_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [23:0] cpu_addr = 24'd0;
  logic [15:0] cpu_wdata = 16'd0;
  logic        sel = 1'b0;

  logic        a_busy, a_done, a_req, a_rw, b_busy, b_done, b_req, b_rw;
  logic [15:0] a_rdata, a_wdata, a_mrdata, b_rdata, b_wdata, b_mrdata;
  logic [23:0] a_addr, b_addr;

  logic        o_busy, o_done, o_req, o_rw;
  logic [15:0] o_rdata, o_wdata;
  logic [23:0] o_addr;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clock = ~clock;

  // Memory model: a fixed word at 0x000010, otherwise 0xD0 followed by the low address byte.
  function automatic logic [15:0] mem_model(input logic [23:0] addr);
    if (addr == 24'h000010) return 16'hBEEF;
    else return {8'hD0, addr[7:0]};
  endfunction

  assign a_mrdata = mem_model(a_addr);
  assign b_mrdata = mem_model(b_addr);

  mem_access_ctrl u_dut_a (
    .clock(clock), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_busy(a_busy), .cpu_done(a_done),
    .cpu_rdata(a_rdata), .mem_req(a_req), .mem_read_write(a_rw), .mem_addr(a_addr),
    .mem_wdata(a_wdata), .mem_rdata(a_mrdata)
  );

  mem_access_ctrl #(.BLOCK_WAIT(1), .CELL_WAIT(15)) u_dut_b (
    .clock(clock), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_busy(b_busy), .cpu_done(b_done),
    .cpu_rdata(b_rdata), .mem_req(b_req), .mem_read_write(b_rw), .mem_addr(b_addr),
    .mem_wdata(b_wdata), .mem_rdata(b_mrdata)
  );

  assign o_busy  = sel ? b_busy  : a_busy;
  assign o_done  = sel ? b_done  : a_done;
  assign o_req   = sel ? b_req   : a_req;
  assign o_rw    = sel ? b_rw    : a_rw;
  assign o_rdata = sel ? b_rdata : a_rdata;
  assign o_wdata = sel ? b_wdata : a_wdata;
  assign o_addr  = sel ? b_addr  : a_addr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one request for a single edge (edge 0); returns in the cycle after edge 0.
  task automatic start(input logic [23:0] addr, input logic we, input logic [15:0] wdata);
    cpu_req = 1'b1; cpu_addr = addr; cpu_we = we; cpu_wdata = wdata;
    tick();
    cpu_req = 1'b0;
  endtask

  // Observe budget cycles (c = cycle after edge c); optionally pulse cpu_req at cycle pulse_at.
  task automatic watch(input string tag, input logic [23:0] exp_addr, input logic exp_we,
                       input logic [15:0] exp_wdata, input int budget, input int pulse_at,
                       output int nreq, output int ndone, output int done_at);
    int bad = 0;
    nreq = 0; ndone = 0; done_at = -1;
    for (int c = 0; c < budget; c++) begin
      if (o_req) begin
        nreq++;
        if (o_rw !== exp_we || o_addr !== exp_addr || o_wdata !== exp_wdata || o_busy !== 1'b1) bad++;
      end
      if (o_done) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
      if (c == pulse_at) begin
        cpu_req = 1'b1; cpu_addr = 24'h000099;
      end else if (c == pulse_at + 1) begin
        cpu_req = 1'b0;
      end
      tick();
    end
    check({tag, ".hold"}, 64'(bad), 64'd0);
  endtask

  int nreq, ndone, done_at, d1, d2, nd;

  initial begin
    // Reset state
    #2;
    check("reset.a", {a_busy, a_done, a_req, a_rw, a_rdata, a_addr, a_wdata}, 64'd0);
    check("reset.b", {b_busy, b_done, b_req, b_rw, b_rdata, b_addr, b_wdata}, 64'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // 1: block read
    start(24'h000010, 1'b0, 16'h0000);
    watch("t1", 24'h000010, 1'b0, 16'h0000, 5, -1, nreq, ndone, done_at);
    check("t1.req_cycles", 64'(nreq), 64'd2);
    check("t1.done_count", 64'(ndone), 64'd1);
    check("t1.done_at", 64'(done_at), 64'd2);
    check("t1.rdata", 64'(o_rdata), 64'hBEEF);
    check("t1.idle", {o_req, o_busy, o_done, o_rw}, 64'd0);

    // 2: cellular write
    start(24'h010000, 1'b1, 16'h1234);
    watch("t2", 24'h010000, 1'b1, 16'h1234, 11, -1, nreq, ndone, done_at);
    check("t2.req_cycles", 64'(nreq), 64'd8);
    check("t2.done_at", 64'(done_at), 64'd8);
    check("t2.done_count", 64'(ndone), 64'd1);
    check("t2.rdata_kept", 64'(o_rdata), 64'hBEEF);

    // 3: back-to-back reads with cpu_req held high
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h000020;
    tick();
    cpu_addr = 24'h000021;
    d1 = -1; d2 = -1; nd = 0;
    for (int c = 0; c < 10; c++) begin
      if (o_done) begin
        if (nd == 0) begin
          d1 = c; check("t3.rdata1", 64'(o_rdata), 64'hD020);
        end else if (nd == 1) begin
          d2 = c; check("t3.rdata2", 64'(o_rdata), 64'hD021);
        end
        nd++;
      end
      if (c == 3) begin
        check("t3.second_access", {o_req, o_busy, o_addr}, {38'd0, 1'b1, 1'b1, 24'h000021});
        cpu_req = 1'b0;
      end
      tick();
    end
    check("t3.done_count", 64'(nd), 64'd2);
    check("t3.first_done", 64'(d1), 64'd2);
    check("t3.spacing", 64'(d2 - d1), 64'd3);

    // 4: request while busy is ignored
    start(24'h010000, 1'b0, 16'h1234);
    watch("t4", 24'h010000, 1'b0, 16'h1234, 11, 2, nreq, ndone, done_at);
    check("t4.req_cycles", 64'(nreq), 64'd8);
    check("t4.done_count", 64'(ndone), 64'd1);
    check("t4.addr_kept", 64'(o_addr), 64'h010000);
    check("t4.rdata", 64'(o_rdata), 64'hD000);
    check("t4.idle", {o_req, o_busy, o_done}, 64'd0);

    // 5: asynchronous reset in cellular ACCESS cycle 4
    start(24'h010000, 1'b1, 16'h5555);
    tick(); tick(); tick();
    check("t5.busy_before", {o_req, o_busy}, 64'd3);
    #2 reset = 1'b1;
    #1;
    check("t5.async_drop", {o_req, o_busy}, 64'd0);
    check("t5.outs_zero", {o_done, o_rw, o_rdata, o_addr, o_wdata}, 64'd0);
    nd = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (o_done) nd++;
    end
    check("t5.no_done", 64'(nd), 64'd0);
    reset = 1'b0;
    tick();
    start(24'h000010, 1'b0, 16'h0000);
    watch("t5b", 24'h000010, 1'b0, 16'h0000, 5, -1, nreq, ndone, done_at);
    check("t5.after_req", 64'(nreq), 64'd2);
    check("t5.after_rdata", 64'(o_rdata), 64'hBEEF);

    // 6: N=1 and N=15 boundary addresses on the second instance
    sel = 1'b1;
    start(24'h00FFFF, 1'b0, 16'h0000);
    watch("t6a", 24'h00FFFF, 1'b0, 16'h0000, 4, -1, nreq, ndone, done_at);
    check("t6.block_req", 64'(nreq), 64'd1);
    check("t6.block_done_at", 64'(done_at), 64'd1);
    check("t6.block_rdata", 64'(o_rdata), 64'hD0FF);
    start(24'h010000, 1'b0, 16'h0000);
    watch("t6b", 24'h010000, 1'b0, 16'h0000, 18, -1, nreq, ndone, done_at);
    check("t6.cell_req", 64'(nreq), 64'd15);
    check("t6.cell_done_at", 64'(done_at), 64'd15);
    check("t6.cell_rdata", 64'(o_rdata), 64'hD000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
